// File: rtl/conv_pkg.sv
// Shared widths, arithmetic helpers and the lane index type for the slice-sum
// output stage.
package conv_pkg;

    localparam int CALC_W     = 64;
    localparam int LANE_IDX_W = 8;

    typedef logic [LANE_IDX_W-1:0]    lane_idx_t;
    typedef logic signed [CALC_W-1:0] calc_t;

    function automatic int result_width(input int image_w, input int weight_w);
        return image_w + weight_w + 1;
    endfunction

    function automatic int sum_width(input int result_w, input int slice_nb);
        return result_w + $clog2(slice_nb + 1);
    endfunction

    // Round half toward +inf, then arithmetic shift; shift of 0 passes through.
    function automatic calc_t round_shift(input calc_t x, input int shift);
        calc_t r;
        if (shift > 0) begin
            r = (x + (64'sd1 <<< (shift - 1))) >>> shift;
        end else begin
            r = x;
        end
        return r;
    endfunction

    function automatic calc_t sat_signed(input calc_t x, input int out_w);
        calc_t hi;
        calc_t lo;
        calc_t r;
        hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (out_w - 1));
        if (x > hi) begin
            r = hi;
        end else if (x < lo) begin
            r = lo;
        end else begin
            r = x;
        end
        return r;
    endfunction

endpackage

// File: rtl/slice_sum_pack_if.sv
// Slice-result input bundle and packed-pixel output bundle of slice_sum_pack.
interface slice_sum_pack_if
    import conv_pkg::*;
#(
    parameter int SLICE_NB     = 3,
    parameter int IMAGE_WIDTH  = 16,
    parameter int WEIGHT_WIDTH = 16,
    parameter int OUT_WIDTH    = 16,
    parameter int PACK_NB      = 4
) ();
    localparam int RESULT_WIDTH = result_width(IMAGE_WIDTH, WEIGHT_WIDTH);

    logic [RESULT_WIDTH-1:0]          bias;
    logic                             bias_valid;
    logic [RESULT_WIDTH*SLICE_NB-1:0] result;
    logic [SLICE_NB-1:0]              result_valid;
    logic                             result_last;
    logic [OUT_WIDTH*PACK_NB-1:0]     out_data;
    logic [PACK_NB-1:0]               out_keep;
    logic                             out_valid;
    logic                             out_last;
    logic                             error;

    modport master (
        output bias, bias_valid, result, result_valid, result_last,
        input  out_data, out_keep, out_valid, out_last, error
    );

    modport slave (
        input  bias, bias_valid, result, result_valid, result_last,
        output out_data, out_keep, out_valid, out_last, error
    );
endinterface

// File: rtl/pixel_pack.sv
// Lane counter and holding word: packs saturated pixels into output words and
// flushes early when a pixel carries end-of-row.
module pixel_pack
    import conv_pkg::*;
#(
    parameter int OUT_WIDTH = 16,
    parameter int PACK_NB   = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              pix_valid,
    input  logic [OUT_WIDTH-1:0]              pix,
    input  logic                              pix_last,
    output logic [PACK_NB-1:0][OUT_WIDTH-1:0] out_data,
    output logic [PACK_NB-1:0]                out_keep,
    output logic                              out_valid,
    output logic                              out_last
);

    lane_idx_t                         cnt_r;
    logic [PACK_NB-1:0][OUT_WIDTH-1:0] word_r;
    logic [PACK_NB-1:0][OUT_WIDTH-1:0] word_s;
    logic [PACK_NB-1:0]                keep_r;
    logic [PACK_NB-1:0]                keep_s;
    logic [PACK_NB-1:0][OUT_WIDTH-1:0] out_data_r;
    logic [PACK_NB-1:0]                out_keep_r;
    logic                              out_valid_r;
    logic                              out_last_r;
    logic                              close_s;

    // Merge the incoming pixel into lane[cnt] and decide whether the word closes.
    always_comb begin
        word_s  = word_r;
        keep_s  = keep_r;
        for (int i = 0; i < PACK_NB; i++) begin
            word_s[i] = (pix_valid && (cnt_r == lane_idx_t'(i))) ? pix  : word_r[i];
            keep_s[i] = (pix_valid && (cnt_r == lane_idx_t'(i))) ? 1'b1 : keep_r[i];
        end
        close_s = pix_valid && ((cnt_r == lane_idx_t'(PACK_NB - 1)) || pix_last);
    end

    // Holding word update and single-cycle word strobe; out_data holds between strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r       <= lane_idx_t'(0);
            word_r      <= {(PACK_NB*OUT_WIDTH){1'b0}};
            keep_r      <= {PACK_NB{1'b0}};
            out_data_r  <= {(PACK_NB*OUT_WIDTH){1'b0}};
            out_keep_r  <= {PACK_NB{1'b0}};
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
        end else begin
            out_keep_r  <= {PACK_NB{1'b0}};
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
            if (close_s) begin
                out_data_r  <= word_s;
                out_keep_r  <= keep_s;
                out_valid_r <= 1'b1;
                out_last_r  <= pix_last;
                cnt_r       <= lane_idx_t'(0);
                word_r      <= {(PACK_NB*OUT_WIDTH){1'b0}};
                keep_r      <= {PACK_NB{1'b0}};
            end else if (pix_valid) begin
                word_r <= word_s;
                keep_r <= keep_s;
                cnt_r  <= cnt_r + lane_idx_t'(1);
            end else begin
                word_r <= word_r;
                keep_r <= keep_r;
                cnt_r  <= cnt_r;
            end
        end
    end

    assign out_data  = out_data_r;
    assign out_keep  = out_keep_r;
    assign out_valid = out_valid_r;
    assign out_last  = out_last_r;

endmodule

// File: rtl/slice_sum_pack.sv
// Sums same-cycle slice results with a per-channel bias, then rounds, shifts,
// saturates and optionally ReLU-clips each pixel before packing into words.
module slice_sum_pack
    import conv_pkg::*;
#(
    parameter int SLICE_NB     = 3,
    parameter int IMAGE_WIDTH  = 16,
    parameter int WEIGHT_WIDTH = 16,
    parameter int OUT_WIDTH    = 16,
    parameter int SHIFT        = 14,
    parameter int PACK_NB      = 4,
    parameter int RELU         = 1
) (
    input logic              clk,
    input logic              rst,
    slice_sum_pack_if.slave  bus
);

    localparam int RESULT_WIDTH = result_width(IMAGE_WIDTH, WEIGHT_WIDTH);
    localparam int SUM_WIDTH    = sum_width(RESULT_WIDTH, SLICE_NB);

    logic signed [RESULT_WIDTH-1:0] bias_r;
    logic signed [SUM_WIDTH-1:0]    sum_s;
    logic signed [SUM_WIDTH-1:0]    sum1_r;
    logic signed [SUM_WIDTH-1:0]    rnd2_r;
    calc_t                          sat_s;
    logic [OUT_WIDTH-1:0]           pix_s;
    logic [OUT_WIDTH-1:0]           pix3_r;
    logic                           accept_s;
    logic                           bad_s;
    logic                           v1_r, v2_r, v3_r;
    logic                           l1_r, l2_r, l3_r;
    logic                           error_r;

    // Sample acceptance: all-ones accepts, all-zeros idles, anything else is an error.
    always_comb begin
        accept_s = &bus.result_valid;
        bad_s    = (|bus.result_valid) && !accept_s;
    end

    // Sign-extended sum of all slices plus the registered bias.
    always_comb begin
        sum_s = SUM_WIDTH'(bias_r);
        for (int i = 0; i < SLICE_NB; i++) begin
            sum_s = sum_s + SUM_WIDTH'($signed(bus.result[i*RESULT_WIDTH +: RESULT_WIDTH]));
        end
    end

    // Saturate to the output width and optionally clip negatives.
    always_comb begin
        sat_s = sat_signed(calc_t'(rnd2_r), OUT_WIDTH);
        if ((RELU != 0) && (sat_s < 64'sd0)) begin
            pix_s = {OUT_WIDTH{1'b0}};
        end else begin
            pix_s = OUT_WIDTH'(sat_s);
        end
    end

    // Bias register, three-stage arithmetic pipeline and sticky error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            bias_r  <= {RESULT_WIDTH{1'b0}};
            sum1_r  <= {SUM_WIDTH{1'b0}};
            rnd2_r  <= {SUM_WIDTH{1'b0}};
            pix3_r  <= {OUT_WIDTH{1'b0}};
            v1_r    <= 1'b0;
            v2_r    <= 1'b0;
            v3_r    <= 1'b0;
            l1_r    <= 1'b0;
            l2_r    <= 1'b0;
            l3_r    <= 1'b0;
            error_r <= 1'b0;
        end else begin
            bias_r  <= bus.bias_valid ? $signed(bus.bias) : bias_r;
            sum1_r  <= sum_s;
            v1_r    <= accept_s;
            l1_r    <= accept_s && bus.result_last;
            rnd2_r  <= SUM_WIDTH'(round_shift(calc_t'(sum1_r), SHIFT));
            v2_r    <= v1_r;
            l2_r    <= l1_r;
            pix3_r  <= pix_s;
            v3_r    <= v2_r;
            l3_r    <= l2_r;
            error_r <= error_r | bad_s;
        end
    end

    pixel_pack #(
        .OUT_WIDTH (OUT_WIDTH),
        .PACK_NB   (PACK_NB)
    ) u_pixel_pack (
        .clk       (clk),
        .rst       (rst),
        .pix_valid (v3_r),
        .pix       (pix3_r),
        .pix_last  (l3_r),
        .out_data  (bus.out_data),
        .out_keep  (bus.out_keep),
        .out_valid (bus.out_valid),
        .out_last  (bus.out_last)
    );

    assign bus.error = error_r;

endmodule

// File: tb/tb_slice_sum_pack.sv
// Directed and randomized bench for slice_sum_pack with RELU=1 and RELU=0 instances
// sharing one stimulus stream, checked against an arithmetic reference model.
module tb_slice_sum_pack;
    localparam int SHIFT = 14;
    localparam int PN    = 4;

    typedef struct {
        int          due;
        logic [63:0] d1;
        logic [63:0] d0;
        logic [3:0]  keep;
        logic        last;
    } word_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    slice_sum_pack_if bus1 ();
    slice_sum_pack_if bus0 ();

    assign bus0.bias         = bus1.bias;
    assign bus0.bias_valid   = bus1.bias_valid;
    assign bus0.result       = bus1.result;
    assign bus0.result_valid = bus1.result_valid;
    assign bus0.result_last  = bus1.result_last;

    slice_sum_pack #(.RELU(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
    slice_sum_pack #(.RELU(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));

    word_t       exp_q[$];
    int          vectors     = 0;
    int          miscompares = 0;
    int          cyc         = 0;
    longint      bias_m;
    bit          err_m;
    int          nl;
    logic [63:0] acc1, acc0, hold1, hold0;

    function automatic longint model_pix(input longint total, input bit relu);
        longint r;
        r = (total + (64'sd1 <<< (SHIFT - 1))) >>> SHIFT;
        if (r > 64'sd32767)  r = 64'sd32767;
        if (r < -64'sd32768) r = -64'sd32768;
        if (relu && (r < 64'sd0)) r = 64'sd0;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        exp_q.delete();
        bias_m = 64'sd0;
        err_m  = 1'b0;
        nl     = 0;
        acc1   = 64'd0;
        acc0   = 64'd0;
        hold1  = 64'd0;
        hold0  = 64'd0;
    endtask

    task automatic check_outputs();
        word_t w;
        if ((exp_q.size() > 0) && (exp_q[0].due == cyc)) begin
            w = exp_q.pop_front();
            chk("strobe",     64'(bus1.out_valid), 64'd1);
            chk("data_relu1", bus1.out_data, w.d1);
            chk("data_relu0", bus0.out_data, w.d0);
            chk("keep",       64'(bus1.out_keep), 64'(w.keep));
            chk("last",       64'(bus1.out_last), 64'(w.last));
            hold1 = w.d1;
            hold0 = w.d0;
        end else begin
            chk("no_strobe",  64'(bus1.out_valid), 64'd0);
            chk("idle_keep",  64'(bus1.out_keep), 64'd0);
            chk("idle_last",  64'(bus1.out_last), 64'd0);
            chk("hold_relu1", bus1.out_data, hold1);
            chk("hold_relu0", bus0.out_data, hold0);
        end
        chk("error_relu1", 64'(bus1.error), 64'(err_m));
        chk("error_relu0", 64'(bus0.error), 64'(err_m));
    endtask

    task automatic step(input logic [2:0] rv, input longint s0, input longint s1,
                        input longint s2, input logic last, input logic bv, input longint b);
        longint t, p1, p0;
        int     k;
        word_t  w;
        bus1.result_valid = rv;
        bus1.result       = {s2[32:0], s1[32:0], s0[32:0]};
        bus1.result_last  = last;
        bus1.bias_valid   = bv;
        bus1.bias         = b[32:0];
        if (rv == 3'b111) begin
            t    = s0 + s1 + s2 + bias_m;
            p1   = model_pix(t, 1'b1);
            p0   = model_pix(t, 1'b0);
            acc1 = acc1 | ((64'(p1) & 64'hFFFF) << (16 * nl));
            acc0 = acc0 | ((64'(p0) & 64'hFFFF) << (16 * nl));
            nl++;
            if ((nl == PN) || last) begin
                k      = (1 << nl) - 1;
                w.due  = cyc + 4;
                w.d1   = acc1;
                w.d0   = acc0;
                w.keep = k[3:0];
                w.last = last;
                exp_q.push_back(w);
                acc1 = 64'd0;
                acc0 = 64'd0;
                nl   = 0;
            end
        end else if (rv != 3'b000) begin
            err_m = 1'b1;
        end
        if (bv) bias_m = b;
        @(posedge clk);
        #1;
        cyc++;
        check_outputs();
    endtask

    task automatic pix_step(input longint p, input logic last);
        step(3'b111, p * 64'sd16384, 64'sd0, 64'sd0, last, 1'b0, 64'sd0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(3'b000, 64'sd0, 64'sd0, 64'sd0, 1'b0, 1'b0, 64'sd0);
    endtask

    task automatic do_reset(input int n);
        bus1.result_valid = 3'b000;
        bus1.result_last  = 1'b0;
        bus1.bias_valid   = 1'b0;
        rst = 1'b1;
        model_clear();
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        rst = 1'b0;
        chk("rst_data",  bus1.out_data, 64'd0);
        chk("rst_keep",  64'(bus1.out_keep), 64'd0);
        chk("rst_valid", 64'(bus1.out_valid), 64'd0);
        chk("rst_last",  64'(bus1.out_last), 64'd0);
        chk("rst_error", 64'(bus1.error), 64'd0);
    endtask

    function automatic longint rand_val(input int mode);
        logic [63:0] raw;
        longint      v;
        if (mode == 0) begin
            raw = {$urandom, $urandom};
            v   = longint'(raw) >>> 31;
        end else begin
            v = longint'($urandom_range(0, 2097152)) - 64'sd1048576;
        end
        return v;
    endfunction

    initial begin
        logic [2:0] rv;
        int         r, mode;
        bus1.result = '0;
        bus1.bias   = '0;
        do_reset(3);

        // Three slices of 2^14 with last -> pixel 3 alone in lane 0.
        step(3'b111, 64'sd16384, 64'sd16384, 64'sd16384, 1'b1, 1'b0, 64'sd0);
        idle(5);

        // Rounding ties, saturation and ReLU in one word.
        step(3'b111, 64'sd8192, 64'sd0, 64'sd0, 1'b0, 1'b0, 64'sd0);
        step(3'b111, 64'sd8191, 64'sd0, 64'sd0, 1'b0, 1'b0, 64'sd0);
        step(3'b111, 64'sd655360000, 64'sd0, 64'sd0, 1'b0, 1'b0, 64'sd0);
        step(3'b111, -64'sd16384, 64'sd0, 64'sd0, 1'b0, 1'b0, 64'sd0);
        idle(5);

        // Continuous full words, back to back.
        for (int i = 0; i < 12; i++) pix_step(longint'((i % 4) + 1), 1'b0);
        // Early flush on end-of-row, next word restarts at lane 0.
        pix_step(64'sd5, 1'b0);
        pix_step(64'sd6, 1'b1);
        for (int i = 0; i < 4; i++) pix_step(longint'(i + 7), 1'b0);
        idle(5);

        // Mismatched valids: sticky error, sample dropped, lane count untouched.
        pix_step(64'sd1, 1'b0);
        step(3'b101, 64'sd16384, 64'sd16384, 64'sd16384, 1'b1, 1'b0, 64'sd0);
        pix_step(64'sd2, 1'b0);
        pix_step(64'sd3, 1'b0);
        pix_step(64'sd4, 1'b0);
        idle(2);
        // Bias load one cycle ahead of a zero-sum sample.
        step(3'b000, 64'sd0, 64'sd0, 64'sd0, 1'b0, 1'b1, 64'sd16384);
        step(3'b111, 64'sd0, 64'sd0, 64'sd0, 1'b1, 1'b0, 64'sd0);
        step(3'b000, 64'sd0, 64'sd0, 64'sd0, 1'b0, 1'b1, 64'sd0);
        idle(5);

        // Reset after two lanes: partial word discarded, error cleared.
        pix_step(64'sd9, 1'b0);
        pix_step(64'sd8, 1'b0);
        idle(3);
        do_reset(2);
        for (int i = 0; i < 4; i++) pix_step(longint'(i + 11), 1'b0);
        idle(5);

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            r = $urandom_range(0, 31);
            if (r < 22)       rv = 3'b111;
            else if (r < 31)  rv = 3'b000;
            else              rv = 3'($urandom_range(1, 6));
            mode = $urandom_range(0, 2);
            step(rv, rand_val(mode), rand_val(mode), rand_val(mode),
                 1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 9) == 0),
                 rand_val($urandom_range(0, 3)));
        end
        idle(6);
        chk("drained", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/slice_sum_pack.md
Name: slice_sum_pack

Overview:
- Downstream stage of a kernel's set of convolution slices.
- Takes the per-slice partial results, which arrive in the same cycle. Sums them with a per-channel bias, then rounds, shifts, saturates and optionally ReLU-clips to the output pixel width.
- Packs PACK_NB output pixels into one output word.
- A word is flushed early on end-of-row.
- Feeds the output writer/DMA; the path has no backpressure.

Parameters:
- SLICE_NB, 3, number of slices (kernel rows) summed.
- IMAGE_WIDTH, 16, pixel width at the slice input.
- WEIGHT_WIDTH, 16, weight width at the slice input.
- RESULT_WIDTH, IMAGE_WIDTH+WEIGHT_WIDTH+1, localparam, width of each slice result.
- SUM_WIDTH, RESULT_WIDTH+$clog2(SLICE_NB+1), localparam, accumulator width. Cannot overflow.
- OUT_WIDTH, 16, output pixel width.
- SHIFT, 14, arithmetic right shift applied after rounding. Range 0..SUM_WIDTH-2.
- PACK_NB, 4, pixels per output word.
- RELU, 1, 1 clamps negative results to 0.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- bias  in  RESULT_WIDTH  signed bias value
- bias_valid  in  1  load bias register
- result  in  RESULT_WIDTH*SLICE_NB  signed slice results; slice 0 in the LSBs
- result_valid  in  SLICE_NB  per-slice valid; all bits are expected equal
- result_last  in  1  last pixel of the image row; qualified by an accepted sample
- out_data  out  OUT_WIDTH*PACK_NB  packed pixels; lane 0 in the LSBs
- out_keep  out  PACK_NB  lane-valid mask
- out_valid  out  1  single-cycle word strobe
- out_last  out  1  word closes a row; qualified by out_valid
- error  out  1  sticky flag for a result_valid mismatch

Behaviour:
- **Reset:** out_data=0, out_keep=0, out_valid=0, out_last=0, error=0. Lane counter=0, bias register=0, all pipeline valids=0. Asserting rst mid-word discards the partial word; no word is emitted.
- **Acceptance:**
  - A sample is accepted when result_valid is all-ones.
  - All-zeros means idle.
  - Any other pattern sets error (sticky until rst) and the sample is dropped; result_last is ignored in that cycle.
- **Bias:** registered on bias_valid. A load in cycle N applies to samples accepted in cycle N+1 onward.
- **S1 (cycle +1):** sum = sign-extended sum of all slice results + bias, at SUM_WIDTH.
- **S2 (cycle +2):**
  - If SHIFT>0: add 2^(SHIFT-1) (round half toward +inf), then arithmetic shift right by SHIFT.
  - If SHIFT=0: pass the value through.
- **S3 (cycle +3):**
  - Saturate to signed OUT_WIDTH: max 2^(OUT_WIDTH-1)-1, min -2^(OUT_WIDTH-1).
  - If RELU, negatives become 0.
  - The value is written to lane[cnt] of the holding word.
- **Word close:**
  - A word closes when cnt==PACK_NB-1 or the sample carries last (last travels down the pipe with the sample).
  - On close, the next cycle drives out_valid=1, out_data=word, out_keep=lanes written, out_last=carried last. Lanes not written are 0.
  - cnt returns to 0 and the holding word clears.
  - Full word and last in the same sample: one word is emitted, with keep all-ones and out_last=1.
- **Latency:** 4 cycles from accepting the closing sample to out_valid.
- **Outputs outside strobes:** out_valid, out_last and out_keep drop to 0 the cycle after a strobe; out_data holds its value.
- **Throughput:** one sample per cycle sustained; back-to-back words are allowed.

Decomposition:
- Shared package conv_pkg holds:
  - the RESULT_WIDTH/SUM_WIDTH width functions;
  - sat_signed and round_shift as automatic functions;
  - a typedef for the packed word lane index.
- One sub-module, pixel_pack: the lane counter, holding word, last/flush logic and output registers. The top-level block holds the sum, round and saturate pipeline.

Test Plan:
1. Three slices each 16384 (2^14), bias 0, SHIFT=14 -> pixel 3 appears in lane 0 four cycles after the closing sample.
2. Rounding: slice total 8192 -> 1; total 8191 -> 0. Saturation: total 40000*2^14 -> 32767. RELU=1 with total -16384 -> 0. RELU=0 with the same total -> -1 (0xFFFF).
3. Pixels 1,2,3,4 on consecutive cycles -> a single strobe with out_data=0x0004_0003_0002_0001, keep=4'b1111, last=0. Repeat continuously: one strobe every 4 cycles, with no gaps.
4. Pixels 5,6 with last on 6 -> out_data=0x0000_0000_0006_0005, keep=4'b0011, out_last=1. The next word starts at lane 0.
5. result_valid=3'b101 -> error=1 and stays 1, no lane is written, and the cnt value is unchanged. bias_valid with bias=16384 one cycle before a zero-sum sample -> pixel 1.
6. rst asserted after 2 of 4 lanes are written -> no strobe and error=0. The next 4 pixels form a complete word.
